// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer, its instruction/operand memory and the control unit.
// master = sequencer side, slave = memory / control-unit / datapath side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              run;
  logic [ADDR_W+3:0] memRdata;
  logic              stop;
  logic              pcWR;
  logic              accWR;
  logic              memWR;
  logic [3:0]        ins;
  logic [ADDR_W-1:0] memAddr;
  logic              memRd;
  logic              memWe;
  logic              accWe;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  modport master (
    input  run, memRdata, stop, pcWR, accWR, memWR,
    output ins, memAddr, memRd, memWe, accWe, pc, busy, halted
  );

  modport slave (
    output run, memRdata, stop, pcWR, accWR, memWR,
    input  ins, memAddr, memRd, memWe, accWe, pc, busy, halted
  );
endinterface

// File: rtl/instr_sequencer.sv
// Four-cycle FETCH/LOAD/OPER/COMMIT sequencer: owns PC and IR, drives memory reads,
// and turns the control-unit decode into single-cycle accumulator/memory write strobes.
module instr_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    OPER   = 3'd3,
    COMMIT = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t            state_r;
  // IR is held as {ins_r, operand_r}; the opcode half doubles as the registered ins output.
  logic [3:0]        ins_r;
  logic [ADDR_W-1:0] operand_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic              mem_we_r;
  logic              acc_we_r;
  logic              busy_r;
  logic              halted_r;
  logic [ADDR_W-1:0] next_pc_s;

  assign next_pc_s = bus.pcWR ? operand_r : pc_r;

  assign bus.ins     = ins_r;
  assign bus.memAddr = mem_addr_r;
  assign bus.memRd   = mem_rd_r;
  assign bus.memWe   = mem_we_r;
  assign bus.accWe   = acc_we_r;
  assign bus.pc      = pc_r;
  assign bus.busy    = busy_r;
  assign bus.halted  = halted_r;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ins_r      <= 4'b0000;
      operand_r  <= {ADDR_W{1'b0}};
      pc_r       <= {ADDR_W{1'b0}};
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_rd_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      acc_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_we_r <= 1'b0;
          acc_we_r <= 1'b0;
          halted_r <= 1'b0;
          if (bus.run) begin
            state_r    <= FETCH;
            mem_addr_r <= pc_r;
            mem_rd_r   <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r  <= IDLE;
            mem_rd_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        FETCH: begin
          state_r  <= LOAD;
          mem_rd_r <= 1'b0;
        end
        LOAD: begin
          state_r    <= OPER;
          ins_r      <= bus.memRdata[ADDR_W+3:ADDR_W];
          operand_r  <= bus.memRdata[ADDR_W-1:0];
          pc_r       <= pc_r + ADDR_W'(1);
          mem_addr_r <= bus.memRdata[ADDR_W-1:0];
          mem_rd_r   <= 1'b1;
        end
        OPER: begin
          // ins is already stable here, so the decode is registered to land exactly in COMMIT.
          state_r  <= COMMIT;
          mem_rd_r <= 1'b0;
          acc_we_r <= bus.accWR & ~bus.stop;
          mem_we_r <= bus.memWR & ~bus.stop;
        end
        COMMIT: begin
          acc_we_r <= 1'b0;
          mem_we_r <= 1'b0;
          if (bus.stop) begin
            state_r  <= HALT;
            busy_r   <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            pc_r <= next_pc_s;
            if (bus.run) begin
              state_r    <= FETCH;
              mem_addr_r <= next_pc_s;
              mem_rd_r   <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        HALT: begin
          mem_we_r <= 1'b0;
          acc_we_r <= 1'b0;
          if (bus.run) begin
            state_r    <= FETCH;
            mem_addr_r <= pc_r;
            mem_rd_r   <= 1'b1;
            busy_r     <= 1'b1;
            halted_r   <= 1'b0;
          end else begin
            state_r  <= HALT;
            mem_rd_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          mem_rd_r <= 1'b0;
          mem_we_r <= 1'b0;
          acc_we_r <= 1'b0;
          busy_r   <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
